// File: rtl/hb_ram_model.sv
// Synthesizable single-clock HyperBus/HyperRAM device model on split-bus controller pins.
// Defining HB_RAM_MODEL_CHECK_EN adds a sticky protocol-error output, err.
module hb_ram_model #(
    parameter int          DQ_W          = 8,
    parameter int          ADDR_W        = 12,
    parameter int          LATENCY       = 6,
    parameter bit          FIXED_LATENCY = 1'b1,
    parameter logic [15:0] ID0           = 16'h0C81
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            hb_clk_o,
    input  logic            hb_cs_o,
    input  logic            hb_rst_o,
    input  logic            hb_rwds_o,
    input  logic            hb_rwds_dir,
    output logic            hb_rwds_i,
    input  logic [DQ_W-1:0] hb_dq_o,
    input  logic            hb_dq_dir,
    output logic [DQ_W-1:0] hb_dq_i,
    output logic            busy
`ifdef HB_RAM_MODEL_CHECK_EN
    ,
    output logic            err
`endif
);

    localparam bit          WIDE      = (DQ_W == 16);
    localparam int          CA_BEATS  = 48 / DQ_W;
    localparam logic [5:0]  LAT_SHORT = 6'(LATENCY * 2);
    localparam logic [5:0]  LAT_LONG  = 6'(LATENCY * 4);
    localparam logic [15:0] CR0_RST   = {12'h8F1, FIXED_LATENCY, 3'b111};

    typedef enum logic [2:0] {S_IDLE, S_CA, S_LAT, S_RD, S_WR, S_REGWR} state_e;
    typedef enum logic [1:0] {REG_ZERO, REG_ID0, REG_CR0} reg_e;

    state_e              state_q, state_d;
    reg_e                reg_q, reg_d;
    logic                ck_q;
    logic [5:0]          cnt_q, cnt_d;
    logic [47-DQ_W:0]    ca_q, ca_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                is_rd_q, is_rd_d;
    logic                is_reg_q, is_reg_d;
    logic                ph_q, ph_d;
    logic [7:0]          hi_byte_q, hi_byte_d;
    logic                hi_mask_q, hi_mask_d;
    logic                reg_done_q, reg_done_d;
    logic [15:0]         cr0_q, cr0_d;
    logic [DQ_W-1:0]     dq_q, dq_d;
    logic                rwds_q, rwds_d;

    logic [15:0]         mem [2**ADDR_W];
    logic                mem_we_hi, mem_we_lo;

    logic                edge_det;
    logic                word_done;
    logic [47:0]         ca_next;
    logic [31:0]         ca_waddr;
    logic                unused_ca;
    logic [15:0]         reg_rdata, rd_word, wdata;
    logic [DQ_W-1:0]     rd_beat;

    assign edge_det  = ck_q ^ hb_clk_o;
    assign word_done = WIDE || ph_q;
    assign ca_next   = {ca_q, hb_dq_o};
    assign ca_waddr  = {ca_next[44:16], ca_next[2:0]};
    assign unused_ca = ^{ca_next[45], ca_next[15:3]};

    always_comb begin
        unique case (reg_q)
            REG_ID0: reg_rdata = ID0;
            REG_CR0: reg_rdata = cr0_q;
            default: reg_rdata = 16'h0000;
        endcase
        rd_word = is_reg_q ? reg_rdata : mem[addr_q];
        if (WIDE) rd_beat = DQ_W'(rd_word);
        else      rd_beat = DQ_W'(ph_q ? rd_word[7:0] : rd_word[15:8]);
        // For byte-wide buses the high byte is held until its partner arrives.
        if (WIDE) wdata = 16'(hb_dq_o);
        else      wdata = {hi_byte_q, hb_dq_o[7:0]};
    end

    // NOTE: every variable gets its default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        reg_d      = reg_q;
        cnt_d      = cnt_q;
        ca_d       = ca_q;
        addr_d     = addr_q;
        is_rd_d    = is_rd_q;
        is_reg_d   = is_reg_q;
        ph_d       = ph_q;
        hi_byte_d  = hi_byte_q;
        hi_mask_d  = hi_mask_q;
        reg_done_d = reg_done_q;
        cr0_d      = cr0_q;
        dq_d       = dq_q;
        rwds_d     = rwds_q;
        mem_we_hi  = 1'b0;
        mem_we_lo  = 1'b0;

        if (!hb_rst_o) begin
            state_d    = S_IDLE;
            reg_d      = REG_ZERO;
            cnt_d      = '0;
            ca_d       = '0;
            addr_d     = '0;
            is_rd_d    = 1'b0;
            is_reg_d   = 1'b0;
            ph_d       = 1'b0;
            hi_byte_d  = '0;
            hi_mask_d  = 1'b0;
            reg_done_d = 1'b0;
            cr0_d      = CR0_RST;
            dq_d       = '0;
            rwds_d     = 1'b0;
        end else if (hb_cs_o) begin
            // CS high wins over any CK edge in the same cycle; a half word is dropped.
            state_d = S_IDLE;
            ph_d    = 1'b0;
            dq_d    = '0;
            rwds_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_CA;
                    cnt_d   = '0;
                    dq_d    = '0;
                    rwds_d  = cr0_q[3];
                end
                S_CA: if (edge_det) begin
                    ca_d = ca_next[47-DQ_W:0];
                    if (cnt_q == 6'(CA_BEATS - 1)) begin
                        is_rd_d    = ca_next[47];
                        is_reg_d   = ca_next[46];
                        addr_d     = ca_waddr[ADDR_W-1:0];
                        reg_d      = (ca_waddr == 32'h0000_0000) ? REG_ID0 :
                                     (ca_waddr == 32'h0000_0800) ? REG_CR0 : REG_ZERO;
                        ph_d       = 1'b0;
                        reg_done_d = 1'b0;
                        rwds_d     = 1'b0;
                        if (ca_next[46] && !ca_next[47]) begin
                            state_d = S_REGWR;
                        end else begin
                            state_d = S_LAT;
                            cnt_d   = cr0_q[3] ? LAT_LONG : LAT_SHORT;
                        end
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                S_LAT: if (edge_det) begin
                    cnt_d = cnt_q - 6'd1;
                    if (cnt_q == 6'd1) state_d = is_rd_q ? S_RD : S_WR;
                end
                S_RD: if (edge_det) begin
                    dq_d   = rd_beat;
                    rwds_d = ~ph_q;
                    ph_d   = ~ph_q;
                    if (word_done && !is_reg_q) addr_d = addr_q + ADDR_W'(1);
                end
                S_WR: if (edge_det) begin
                    ph_d = ~ph_q;
                    if (!word_done) begin
                        hi_byte_d = hb_dq_o[7:0];
                        hi_mask_d = hb_rwds_o;
                    end else begin
                        mem_we_hi = WIDE ? ~hb_rwds_o : ~hi_mask_q;
                        mem_we_lo = ~hb_rwds_o;
                        addr_d    = addr_q + ADDR_W'(1);
                    end
                end
                S_REGWR: if (edge_det && !reg_done_q) begin
                    ph_d = ~ph_q;
                    if (!word_done) begin
                        hi_byte_d = hb_dq_o[7:0];
                    end else begin
                        reg_done_d = 1'b1;
                        if (reg_q == REG_CR0) cr0_d = wdata;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            reg_q      <= REG_ZERO;
            ck_q       <= 1'b0;
            cnt_q      <= '0;
            ca_q       <= '0;
            addr_q     <= '0;
            is_rd_q    <= 1'b0;
            is_reg_q   <= 1'b0;
            ph_q       <= 1'b0;
            hi_byte_q  <= '0;
            hi_mask_q  <= 1'b0;
            reg_done_q <= 1'b0;
            cr0_q      <= CR0_RST;
            dq_q       <= '0;
            rwds_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            reg_q      <= reg_d;
            ck_q       <= hb_clk_o;
            cnt_q      <= cnt_d;
            ca_q       <= ca_d;
            addr_q     <= addr_d;
            is_rd_q    <= is_rd_d;
            is_reg_q   <= is_reg_d;
            ph_q       <= ph_d;
            hi_byte_q  <= hi_byte_d;
            hi_mask_q  <= hi_mask_d;
            reg_done_q <= reg_done_d;
            cr0_q      <= cr0_d;
            dq_q       <= dq_d;
            rwds_q     <= rwds_d;
        end
    end

    // NOTE: the array is deliberately not reset; contents survive rst_n and hb_rst_o.
    always_ff @(posedge clk) begin
        if (mem_we_hi) mem[addr_q][15:8] <= wdata[15:8];
        if (mem_we_lo) mem[addr_q][7:0]  <= wdata[7:0];
    end

    assign hb_dq_i   = (hb_dq_dir && hb_rst_o) ? dq_q : '0;
    assign hb_rwds_i = hb_rwds_dir & hb_rst_o & rwds_q;
    assign busy      = rst_n & hb_rst_o & ((state_q != S_IDLE) | ~hb_cs_o);

`ifdef HB_RAM_MODEL_CHECK_EN
    logic err_q;
    logic err_set;

    assign err_set = ((state_q == S_RD) && !hb_dq_dir) ||
                     ((state_q == S_IDLE) && edge_det) ||
                     ((state_q == S_WR) && hb_cs_o && !WIDE && ph_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        err_q <= 1'b0;
        else if (!hb_rst_o) err_q <= 1'b0;
        else if (err_set)  err_q <= 1'b1;
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_hb_ram_model.sv
// Directed bench for hb_ram_model: byte-wide bus, 16-word array, LATENCY 6, fixed latency at reset.
module tb_hb_ram_model;

    logic       clk = 1'b0;
    logic       rst_n, hb_clk_o, hb_cs_o, hb_rst_o;
    logic       hb_rwds_o, hb_rwds_dir, hb_rwds_i, hb_dq_dir, busy;
    logic [7:0] hb_dq_o, hb_dq_i;
`ifdef HB_RAM_MODEL_CHECK_EN
    logic       err;
`endif

    int errors = 0;
    int checks = 0;
    logic [15:0] r0, r1, r2;

    always #5 clk = ~clk;

    hb_ram_model #(
        .DQ_W(8), .ADDR_W(4), .LATENCY(6), .FIXED_LATENCY(1'b1), .ID0(16'h0C81)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .hb_clk_o(hb_clk_o),
        .hb_cs_o(hb_cs_o),
        .hb_rst_o(hb_rst_o),
        .hb_rwds_o(hb_rwds_o),
        .hb_rwds_dir(hb_rwds_dir),
        .hb_rwds_i(hb_rwds_i),
        .hb_dq_o(hb_dq_o),
        .hb_dq_dir(hb_dq_dir),
        .hb_dq_i(hb_dq_i),
        .busy(busy)
`ifdef HB_RAM_MODEL_CHECK_EN
        ,
        .err(err)
`endif
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One CK edge every two model clocks keeps CK at a quarter of clk.
    task automatic ck_edge();
        hb_clk_o = ~hb_clk_o;
        tick(2);
    endtask

    task automatic beat(input logic [7:0] d, input logic m);
        hb_dq_o   = d;
        hb_rwds_o = m;
        ck_edge();
    endtask

    task automatic cs_start();
        hb_cs_o = 1'b0;
        tick(2);
    endtask

    task automatic cs_end();
        hb_cs_o = 1'b1;
        tick(2);
        hb_dq_dir   = 1'b1;
        hb_rwds_dir = 1'b1;
    endtask

    task automatic send_ca(input logic [47:0] ca);
        hb_dq_dir = 1'b0;
        for (int i = 0; i < 6; i++) beat(ca[47-8*i -: 8], 1'b0);
    endtask

    task automatic do_read(input string tag, input logic [47:0] ca, input logic ind,
                           input int lat, input int n,
                           output logic [15:0] w0, output logic [15:0] w1, output logic [15:0] w2);
        logic [15:0] w [3];
        for (int i = 0; i < 3; i++) w[i] = 16'h0000;
        cs_start();
        check($sformatf("%s_ind", tag), 16'(hb_rwds_i), 16'(ind));
        send_ca(ca);
        hb_dq_dir = 1'b1;
        repeat (lat) ck_edge();
        check($sformatf("%s_lat", tag), 16'(hb_dq_i), 16'h0000);
        for (int i = 0; i < n; i++) begin
            ck_edge();
            w[i][15:8] = hb_dq_i;
            check($sformatf("%s_rwds%0d_hi", tag, i), 16'(hb_rwds_i), 16'h0001);
            ck_edge();
            w[i][7:0] = hb_dq_i;
            check($sformatf("%s_rwds%0d_lo", tag, i), 16'(hb_rwds_i), 16'h0000);
        end
        cs_end();
        check($sformatf("%s_busy_end", tag), 16'(busy), 16'h0000);
        check($sformatf("%s_dq_end", tag), 16'(hb_dq_i), 16'h0000);
        w0 = w[0];
        w1 = w[1];
        w2 = w[2];
    endtask

    task automatic do_write(input string tag, input logic [47:0] ca, input logic ind,
                            input int lat, input int n,
                            input logic [15:0] w0, input logic [15:0] w1, input logic hmask0);
        cs_start();
        check($sformatf("%s_ind", tag), 16'(hb_rwds_i), 16'(ind));
        check($sformatf("%s_busy", tag), 16'(busy), 16'h0001);
        send_ca(ca);
        hb_rwds_dir = 1'b0;
        repeat (lat) beat(8'h00, 1'b0);
        beat(w0[15:8], hmask0);
        beat(w0[7:0], 1'b0);
        if (n > 1) begin
            beat(w1[15:8], 1'b0);
            beat(w1[7:0], 1'b0);
        end
        cs_end();
        check($sformatf("%s_busy_end", tag), 16'(busy), 16'h0000);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        hb_clk_o    = 1'b0;
        hb_cs_o     = 1'b1;
        hb_rst_o    = 1'b1;
        hb_rwds_o   = 1'b0;
        hb_rwds_dir = 1'b1;
        hb_dq_o     = 8'h00;
        hb_dq_dir   = 1'b1;
        tick(3);
        check("rst_dq", 16'(hb_dq_i), 16'h0000);
        check("rst_rwds", 16'(hb_rwds_i), 16'h0000);
        check("rst_busy", 16'(busy), 16'h0000);
        rst_n = 1'b1;
        tick(2);

        // CR0 after reset reports fixed (double) latency: 24 edges.
        do_read("cr0_rst", 48'hC000_0100_0000, 1'b1, 24, 1, r0, r1, r2);
        check("cr0_rst_bit3", 16'(r0[3]), 16'h0001);

        do_write("wr_burst", 48'h2000_0000_0000, 1'b1, 24, 2, 16'h1234, 16'hABCD, 1'b0);
        do_read("rd_burst", 48'hA000_0000_0000, 1'b1, 24, 2, r0, r1, r2);
        check("rd_burst_w0", r0, 16'h1234);
        check("rd_burst_w1", r1, 16'hABCD);

        do_write("wr5_clr", 48'h2000_0000_0005, 1'b1, 24, 1, 16'h0000, 16'h0000, 1'b0);
        do_write("wr5_mask", 48'h2000_0000_0005, 1'b1, 24, 1, 16'hFFFF, 16'h0000, 1'b1);
        do_read("rd5", 48'hA000_0000_0005, 1'b1, 24, 1, r0, r1, r2);
        check("rd5_masked", r0, 16'h00FF);

        // Clear CR0[3]; the second word must be ignored or bit 3 would return.
        do_write("cr0_wr", 48'h4000_0100_0000, 1'b1, 0, 2, 16'h8F17, 16'h0008, 1'b0);
        do_read("cr0_rd", 48'hC000_0100_0000, 1'b0, 12, 1, r0, r1, r2);
        check("cr0_rd_val", r0, 16'h8F17);
        do_read("lat12", 48'hA000_0000_0000, 1'b0, 12, 1, r0, r1, r2);
        check("lat12_w0", r0, 16'h1234);

        do_write("wr15", 48'h2000_0001_0007, 1'b0, 12, 1, 16'h5A5A, 16'h0000, 1'b0);
        do_read("wrap", 48'hA000_0001_0007, 1'b0, 12, 3, r0, r1, r2);
        check("wrap_w15", r0, 16'h5A5A);
        check("wrap_w0", r1, 16'h1234);
        check("wrap_w1", r2, 16'hABCD);

        do_read("id0", 48'hC000_0000_0000, 1'b0, 12, 2, r0, r1, r2);
        check("id0_w0", r0, 16'h0C81);
        check("id0_w1", r1, 16'h0C81);
        do_read("reg1", 48'hC000_0000_0001, 1'b0, 12, 1, r0, r1, r2);
        check("reg1_w0", r0, 16'h0000);

        // Abort a read after its first beat; direction pins gate the model outputs.
        cs_start();
        send_ca(48'hA000_0000_0000);
        hb_dq_dir = 1'b1;
        repeat (12) ck_edge();
        ck_edge();
        check("abort_beat0", 16'(hb_dq_i), 16'h0012);
        check("abort_rwds0", 16'(hb_rwds_i), 16'h0001);
        hb_dq_dir   = 1'b0;
        hb_rwds_dir = 1'b0;
        #1;
        check("dir_dq_gate", 16'(hb_dq_i), 16'h0000);
        check("dir_rwds_gate", 16'(hb_rwds_i), 16'h0000);
        hb_dq_dir   = 1'b1;
        hb_rwds_dir = 1'b1;
        #1;
        check("dir_dq_restore", 16'(hb_dq_i), 16'h0012);
        hb_cs_o = 1'b1;
        tick(1);
        check("abort_dq", 16'(hb_dq_i), 16'h0000);
        check("abort_busy", 16'(busy), 16'h0000);
        tick(1);
        do_read("after_abort", 48'hA000_0001_0007, 1'b0, 12, 1, r0, r1, r2);
        check("after_abort_w0", r0, 16'h5A5A);

        // Device reset restores CR0 but keeps the array.
        hb_rst_o = 1'b0;
        tick(2);
        check("hbrst_busy", 16'(busy), 16'h0000);
        check("hbrst_dq", 16'(hb_dq_i), 16'h0000);
        hb_rst_o = 1'b1;
        tick(1);
        do_read("post_hbrst", 48'hA000_0000_0000, 1'b1, 24, 1, r0, r1, r2);
        check("post_hbrst_w0", r0, 16'h1234);

`ifdef HB_RAM_MODEL_CHECK_EN
        check("err_clear", 16'(err), 16'h0000);
        hb_clk_o = ~hb_clk_o;
        tick(2);
        check("err_ck_idle", 16'(err), 16'h0001);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hb_ram_model.md
Name: hb_ram_model

Overview:
- Parametrised, clocked model of a HyperBus/HyperRAM device. It sits on the controller's split-bus pins (separate out/in/dir signals) in the ECP5 simulation bench.
- Replaces the vendor timing-model shim with a synthesizable single-clock memory.
- Oversamples the HyperBus clock pin and decodes command/address (CA).
- Implements fixed or variable initial latency, masked writes, linear bursts and register space.

Parameters:
- DQ_W, 8, data bus width; legal values 8 or 16.
- ADDR_W, 12, word-address width; depth is 2^ADDR_W 16-bit words.
- LATENCY, 6, initial latency in HyperBus clock cycles; legal range 3..7.
- FIXED_LATENCY, 1, reset value of CR0[3]; 1 = always double latency.
- ID0, 16'h0C81, value returned for register read at word address 0.

Ports:
- clk  in  1  model clock; must be at least 4x the HyperBus clock.
- rst_n  in  1  asynchronous active-low reset.
- hb_clk_o  in  1  HyperBus CK from the controller.
- hb_cs_o  in  1  chip select, active low.
- hb_rst_o  in  1  device reset, active low; equivalent to rst_n except for memory contents.
- hb_rwds_o  in  1  RWDS driven by the controller (write mask).
- hb_rwds_dir  in  1  1 = controller not driving RWDS.
- hb_rwds_i  out  1  RWDS driven by the model.
- hb_dq_o  in  DQ_W  DQ driven by the controller.
- hb_dq_dir  in  1  1 = controller not driving DQ.
- hb_dq_i  out  DQ_W  DQ driven by the model.
- busy  out  1  high while a transaction is in progress.

Behaviour:
- Reset (rst_n low, or hb_rst_o low):
  - Outputs hb_dq_i=0, hb_rwds_i=0, busy=0.
  - State=IDLE; CR0[3]=FIXED_LATENCY.
  - Memory array is not cleared.
- Edge detection: ck_q registers hb_clk_o every clk. An edge is any cycle where ck_q != hb_clk_o. All sampling happens on the clk in which the edge is detected.
- Beat definition: each CK edge is one beat. For DQ_W=8, a 16-bit word is two beats, high byte first. For DQ_W=16, one beat is one word.
- Chip-select deassert: hb_cs_o high in any state forces IDLE on the next clk, drives outputs to 0 and clears busy. A partially received word is discarded.
- IDLE -> CA when hb_cs_o falls; busy=1 from the same cycle.
- CA state:
  - Collects 48/DQ_W beats MSB-first into ca[47:0].
  - Drives hb_rwds_i = CR0[3] during CA; this is the latency indication.
  - Decode:
    - ca[47]=1 means read.
    - ca[46]=1 means register space.
    - Word address = {ca[44:16], ca[2:0]}, truncated to ADDR_W.
- CA transitions:
  - Register write -> REGWR (zero latency).
  - Otherwise -> LAT with count = LATENCY*(CR0[3]?2:1)*2 edges.
- LAT: decrements on each edge. At 0, goes to RD or WR.
- RD:
  - Each edge presents the next beat on hb_dq_i, updated one clk after edge detect.
  - hb_rwds_i toggles with every beat: first beat 1, second 0, and so on, i.e. edge-aligned.
  - Address increments after every complete word and wraps from 2^ADDR_W-1 to 0.
  - Register reads: addr 0 -> ID0; addr 1 -> 16'h0000; addr 0x800 -> CR0; else 16'h0000. Address does not increment.
- WR:
  - Each edge samples hb_dq_o.
  - A byte is written only if hb_rwds_o was 0 on that byte's beat.
  - Address increments and wraps as in RD.
- REGWR: the first complete word is written to CR0 if addr==0x800; subsequent beats are ignored.
- Data direction:
  - When hb_dq_dir=0 (controller driving), the model holds hb_dq_i at 0.
  - When hb_rwds_dir=0, the model holds hb_rwds_i at 0.
  - This holds in every state.
- Simultaneous events: a CK edge in the same clk as hb_cs_o rising is ignored; CS wins.

Optional Feature:
- Macro: HB_RAM_MODEL_CHECK_EN.
- When defined, adds output port err (1 bit, reset 0, sticky until reset). err sets on any of:
  - DQ contention: hb_dq_dir=0 while the model is in RD.
  - A CK edge observed while in IDLE.
  - CS released mid-word during WR.
- When not defined, the err port and its logic are absent.

Test Plan:
- Reset with rst_n=0 -> all outputs 0, busy=0; after release, read CR0 returns CR0[3]=1.
- Write burst: CA 0x200000000000 (write, mem, addr 0), data 0x1234,0xABCD with RWDS=0 -> then read at addr 0 returns 0x1234,0xABCD; hb_rwds_i toggles 1,0,1,0.
- Masked write: write 0xFFFF to addr 5 with RWDS=1 on the high-byte beat, over old 0x0000 -> read returns 0x00FF.
- Latency: CR0[3]=1, LATENCY=6 -> first read beat appears after 24 CK edges past the CA; write CR0 with bit3=0 -> next read starts after 12 edges.
- Wrap: ADDR_W=4, read burst of 3 words starting at addr 15 -> words from addr 15, 0, 1.
- CS abort: raise hb_cs_o mid-read -> next clk hb_dq_i=0, busy=0; a new CA is then accepted normally. With HB_RAM_MODEL_CHECK_EN defined, a CK edge in IDLE sets err=1.
